// File: rtl/fixed_divide_issue.sv
// Issue stage in front of the fixed-point divider: operand FIFO, credit
// counter, and a flag pipe that lines divide-by-zero/overflow up with results.
//
// Ports:
//   clk, rstn               clock, async active-low reset
//   in_valid/in_ready, a, b operand pair handshake (in_ready registered)
//   div_valid, div_a, div_b issue strobe and operands to the divider
//   credit_ret              one downstream result slot freed
//   tag_valid/zero/ovf      flags aligned with divider out_valid
//   credit_err              sticky credit_ret-at-full error
module fixed_divide_issue #(
  parameter int BITS = 8,
  parameter logic [127:0] PRECISION = "FIXED_04_04",
  parameter int DEPTH = 4,
  parameter int CREDITS = 4,
  parameter int LATENCY = BITS
    + 10 * (int'(PRECISION[15:8]) - 48)
    + (int'(PRECISION[7:0]) - 48) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            div_valid,
  output logic [BITS-1:0] div_a,
  output logic [BITS-1:0] div_b,
  input  logic            credit_ret,
  output logic            tag_valid,
  output logic            tag_zero,
  output logic            tag_ovf,
  output logic            credit_err
);

  localparam int FRACTION = 10 * (int'(PRECISION[15:8]) - 48)
                          + (int'(PRECISION[7:0]) - 48);
  localparam int SH = BITS - 1 - FRACTION;
  localparam int MW = BITS + FRACTION;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int EW = 2 * BITS + 2;

  localparam logic [BITS-1:0] MINV = {1'b1, {(BITS-1){1'b0}}};

  logic [BITS-2:0] a_mag;
  logic [BITS-2:0] b_mag;
  logic [MW-1:0]   a_ext;
  logic [MW-1:0]   b_shf;
  logic            zero;
  logic            ovf;

  // Magnitudes of the most negative value are meaningless here, but
  // that value is flagged as overflow on its own.
  assign a_mag = a[BITS-1] ? (~a[BITS-2:0] + (BITS-1)'(1)) : a[BITS-2:0];
  assign b_mag = b[BITS-1] ? (~b[BITS-2:0] + (BITS-1)'(1)) : b[BITS-2:0];
  assign a_ext = MW'(a_mag);
  assign b_shf = MW'(b_mag) << SH;
  assign zero  = (b == '0);
  assign ovf   = !zero && (a == MINV || b == MINV || a_ext >= b_shf);

  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wp_q;
  logic [AW-1:0]   rp_q;
  logic [AW:0]     cnt_q;
  logic [AW:0]     cnt_d;
  logic            rdy_q;
  logic [CW-1:0]   cred_q;
  logic [CW-1:0]   cred_d;
  logic            err_q;
  logic            err_d;
  logic            dv_q;
  logic [BITS-1:0] da_q;
  logic [BITS-1:0] db_q;
  logic [LATENCY-1:0] tv_q;
  logic [LATENCY-1:0] tz_q;
  logic [LATENCY-1:0] to_q;
  logic            tvo_q;
  logic            tzo_q;
  logic            too_q;

  logic            push;
  logic            pop;
  logic [BITS-1:0] h_a;
  logic [BITS-1:0] h_b;
  logic            h_z;
  logic            h_o;

  assign push = in_valid && rdy_q;
  assign pop  = (cnt_q != '0) && (cred_q != '0);
  assign {h_a, h_b, h_z, h_o} = mem_q[rp_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // A return with the counter already full saturates and latches an error,
  // unless an issue consumes a credit in the same cycle.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    if (pop && !credit_ret) begin
      cred_d = cred_q - CW'(1);
    end else if (!pop && credit_ret) begin
      if (cred_q == CW'(CREDITS)) begin
        err_d = 1'b1;
      end else begin
        cred_d = cred_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= {a, b, zero, ovf};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b1;
      cred_q <= CW'(CREDITS);
      err_q  <= 1'b0;
      dv_q   <= 1'b0;
      da_q   <= '0;
      db_q   <= '0;
      tv_q   <= '0;
      tz_q   <= '0;
      to_q   <= '0;
      tvo_q  <= 1'b0;
      tzo_q  <= 1'b0;
      too_q  <= 1'b0;
    end else begin
      if (push) begin
        wp_q <= wp_q + AW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + AW'(1);
        da_q <= h_a;
        db_q <= h_b;
      end
      cnt_q  <= cnt_d;
      rdy_q  <= (cnt_d < (AW+1)'(DEPTH));
      cred_q <= cred_d;
      err_q  <= err_d;
      dv_q   <= pop;
      tv_q   <= {tv_q[LATENCY-2:0], pop};
      tz_q   <= {tz_q[LATENCY-2:0], pop && h_z};
      to_q   <= {to_q[LATENCY-2:0], pop && h_o};
      // Output register makes the flags land LATENCY edges after div_valid.
      tvo_q  <= tv_q[LATENCY-1];
      tzo_q  <= tz_q[LATENCY-1];
      too_q  <= to_q[LATENCY-1];
    end
  end

  assign in_ready   = rdy_q;
  assign div_valid  = dv_q;
  assign div_a      = da_q;
  assign div_b      = db_q;
  assign tag_valid  = tvo_q;
  assign tag_zero   = tzo_q;
  assign tag_ovf    = too_q;
  assign credit_err = err_q;

endmodule
